// File: rtl/gfx_timing_gen_if.sv
// gfx_timing_gen_if: enable input and registered timing outputs of the video timing generator
interface gfx_timing_gen_if #(parameter int CW = 11);
  logic          enable;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          de;
  logic          hsync;
  logic          vsync;
  logic          line_start;
  logic          frame_start;
  logic          vblank_irq;
  logic [7:0]    frame_cnt;
  modport master (
    input  enable,
    output x, y, de, hsync, vsync, line_start, frame_start, vblank_irq, frame_cnt
  );
  modport slave (
    output enable,
    input  x, y, de, hsync, vsync, line_start, frame_start, vblank_irq, frame_cnt
  );
endinterface

// File: rtl/gfx_timing_gen.sv
// gfx_timing_gen: video timing generator; registered position, data-enable, syncs and event pulses
module gfx_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CW       = 11
) (
  input  logic              clk,
  input  logic              reset,
  gfx_timing_gen_if.master  bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  logic [CW-1:0] h_q, v_q, h_d, v_d, x_q, y_q;
  logic          de_q, hsync_q, vsync_q, ls_q, fs_q, vb_q, started_q;
  logic          de_d, hsync_d, vsync_d, ls_d, fs_d, vb_d, h_wrap;
  logic [7:0]    fc_q;
  always_comb begin
    h_wrap  = h_q == CW'(H_TOTAL - 1);
    h_d     = h_wrap ? '0 : h_q + CW'(1);
    v_d     = !h_wrap ? v_q : (v_q == CW'(V_TOTAL - 1)) ? '0 : v_q + CW'(1);
    de_d    = (h_q < CW'(H_ACTIVE)) && (v_q < CW'(V_ACTIVE));
    hsync_d = (h_q >= CW'(H_ACTIVE + H_FP)) && (h_q < CW'(H_ACTIVE + H_FP + H_SYNC)) ? SYNC_POL : ~SYNC_POL;
    vsync_d = (v_q >= CW'(V_ACTIVE + V_FP)) && (v_q < CW'(V_ACTIVE + V_FP + V_SYNC)) ? SYNC_POL : ~SYNC_POL;
    ls_d    = h_q == '0;
    fs_d    = ls_d && (v_q == '0);
    vb_d    = ls_d && (v_q == CW'(V_ACTIVE));
  end
  // started_q suppresses the frame count on the very first (0,0) after reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_q       <= '0;
      v_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      de_q      <= 1'b0;
      hsync_q   <= ~SYNC_POL;
      vsync_q   <= ~SYNC_POL;
      ls_q      <= 1'b0;
      fs_q      <= 1'b0;
      vb_q      <= 1'b0;
      fc_q      <= '0;
      started_q <= 1'b0;
    end else if (bus.enable) begin
      h_q       <= h_d;
      v_q       <= v_d;
      x_q       <= h_q;
      y_q       <= v_q;
      de_q      <= de_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      ls_q      <= ls_d;
      fs_q      <= fs_d;
      vb_q      <= vb_d;
      started_q <= 1'b1;
      if (fs_d && started_q) fc_q <= fc_q + 8'd1;
    end else begin
      de_q <= 1'b0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
      vb_q <= 1'b0;
    end
  end
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.de          = de_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.line_start  = ls_q;
  assign bus.frame_start = fs_q;
  assign bus.vblank_irq  = vb_q;
  assign bus.frame_cnt   = fc_q;
endmodule

// File: tb/tb_gfx_timing_gen.sv
// tb_gfx_timing_gen: directed checks of default 640x480 line timing and a tiny geometry for frame behaviour
module tb_gfx_timing_gen;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   checks = 0;
  int   failures = 0;
  always #5 clk = ~clk;
  gfx_timing_gen_if ia ();
  gfx_timing_gen_if ib ();
  gfx_timing_gen u_a (.clk(clk), .reset(rst_a), .bus(ia));
  gfx_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
  ) u_b (.clk(clk), .reset(rst_b), .bus(ib));
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int fs_n;
    int xx, yy;
    rst_a = 1'b0;
    rst_b = 1'b0;
    ia.enable = 1'b0;
    ib.enable = 1'b0;
    repeat (3) tick();
    rst_a = 1'b1;
    ia.enable = 1'b1;
    repeat (51) tick();
    check("a_pre_reset_x", ia.x, 50);
    #3 rst_a = 1'b0;
    #1;
    check("a_rst_x", ia.x, 0);
    check("a_rst_y", ia.y, 0);
    check("a_rst_de", ia.de, 0);
    check("a_rst_hsync", ia.hsync, 1);
    check("a_rst_vsync", ia.vsync, 1);
    check("a_rst_ls", ia.line_start, 0);
    check("a_rst_fs", ia.frame_start, 0);
    check("a_rst_vb", ia.vblank_irq, 0);
    check("a_rst_fc", ia.frame_cnt, 0);
    tick();
    rst_a = 1'b1;
    tick();
    check("a_first_fs", ia.frame_start, 1);
    check("a_first_fc", ia.frame_cnt, 0);
    for (int i = 0; i < 800; i++) begin
      check("a_l0_x", ia.x, i);
      check("a_l0_y", ia.y, 0);
      check("a_l0_de", ia.de, int'(i < 640));
      check("a_l0_hsync", ia.hsync, int'(!(i >= 656 && i < 752)));
      check("a_l0_ls", ia.line_start, int'(i == 0));
      check("a_l0_vsync", ia.vsync, 1);
      tick();
    end
    check("a_l1_x", ia.x, 0);
    check("a_l1_y", ia.y, 1);
    check("a_l1_ls", ia.line_start, 1);
    check("a_l1_fs", ia.frame_start, 0);
    check("a_l1_de", ia.de, 1);
    repeat (100) tick();
    check("a_gap_start_x", ia.x, 100);
    ia.enable = 1'b0;
    repeat (5) begin
      tick();
      check("a_gap_de", ia.de, 0);
      check("a_gap_x", ia.x, 100);
      check("a_gap_hsync", ia.hsync, 1);
      check("a_gap_ls", ia.line_start, 0);
    end
    ia.enable = 1'b1;
    tick();
    check("a_resume_x", ia.x, 101);
    check("a_resume_de", ia.de, 1);
    repeat (599) tick();
    check("a_gap2_x0", ia.x, 700);
    check("a_gap2_hs0", ia.hsync, 0);
    ia.enable = 1'b0;
    repeat (3) begin
      tick();
      check("a_gap2_hsync", ia.hsync, 0);
      check("a_gap2_x", ia.x, 700);
      check("a_gap2_y", ia.y, 1);
    end
    ia.enable = 1'b1;
    tick();
    check("a_resume2_x", ia.x, 701);
    check("a_resume2_hsync", ia.hsync, 0);
    ia.enable = 1'b0;
    rst_b = 1'b1;
    ib.enable = 1'b1;
    tick();
    fs_n = 0;
    for (int f = 0; f < 256; f++) begin
      for (int n = 0; n < 48; n++) begin
        xx = n % 8;
        yy = n / 8;
        fs_n += int'(ib.frame_start);
        check("b_fc", ib.frame_cnt, f % 256);
        if (f < 2) begin
          check("b_x", ib.x, xx);
          check("b_y", ib.y, yy);
          check("b_de", ib.de, int'(xx < 4 && yy < 3));
          check("b_hsync", ib.hsync, int'(xx >= 5 && xx < 7));
          check("b_vsync", ib.vsync, int'(yy == 4));
          check("b_ls", ib.line_start, int'(xx == 0));
          check("b_fs", ib.frame_start, int'(n == 0));
          check("b_vb", ib.vblank_irq, int'(xx == 0 && yy == 3));
        end
        tick();
      end
      if (f == 1) begin
        check("b_fs_count_2frames", fs_n + int'(ib.frame_start), 3);
        check("b_fc_2frames", ib.frame_cnt, 2);
      end
    end
    check("b_wrap_fc", ib.frame_cnt, 0);
    check("b_wrap_fs", ib.frame_start, 1);
    check("b_wrap_x", ib.x, 0);
    check("b_wrap_y", ib.y, 0);
    check("b_fs_count_total", fs_n + int'(ib.frame_start), 257);
    repeat (26) tick();
    check("b_mid_x", ib.x, 2);
    check("b_mid_y", ib.y, 3);
    #2 rst_b = 1'b0;
    #1;
    check("b_rst_x", ib.x, 0);
    check("b_rst_y", ib.y, 0);
    check("b_rst_de", ib.de, 0);
    check("b_rst_hsync", ib.hsync, 0);
    check("b_rst_vsync", ib.vsync, 0);
    check("b_rst_ls", ib.line_start, 0);
    check("b_rst_fs", ib.frame_start, 0);
    check("b_rst_fc", ib.frame_cnt, 0);
    tick();
    rst_b = 1'b1;
    tick();
    check("b_after_x", ib.x, 0);
    check("b_after_y", ib.y, 0);
    check("b_after_fs", ib.frame_start, 1);
    check("b_after_de", ib.de, 1);
    check("b_after_fc", ib.frame_cnt, 0);
    tick();
    check("b_after_x1", ib.x, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
